// File: rtl/pairhmm_compute_arbiter_pkg.sv
// Shared defaults and round-robin index helper for the PairHMM compute arbiter.
// Pure definitions: no logic, no latency, no backpressure.
package pairhmm_compute_arbiter_pkg;

  localparam int DEF_NUM_WORKERS     = 4;
  localparam int DEF_REQ_WIDTH       = 128;
  localparam int DEF_RES_WIDTH       = 96;
  localparam int DEF_MAX_OUTSTANDING = 16;

  // (base + off) mod n, valid for base < n and off < n
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/pairhmm_tag_fifo.sv
// Worker-index tag FIFO with first-word-fall-through head and occupancy count.
// Push visible at head one cycle later; caller guarantees no push when full and no pop when empty.
module pairhmm_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/pairhmm_compute_arbiter.sv
// N:1 round-robin arbiter sharing one PairHMM engine; grants registered (latency 1), results routed combinationally.
// Grants stall on engine full or MAX_OUTSTANDING in flight; results stall head-of-line when the owning worker is full.
module pairhmm_compute_arbiter
  import pairhmm_compute_arbiter_pkg::*;
#(
  parameter int NUM_WORKERS     = DEF_NUM_WORKERS,
  parameter int REQ_WIDTH       = DEF_REQ_WIDTH,
  parameter int RES_WIDTH       = DEF_RES_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                                   clock_i,
  input  logic                                   reset_n_i,
  input  logic                                   enable_i,
  input  logic [NUM_WORKERS-1:0]                 req_write_i,
  input  logic [NUM_WORKERS*REQ_WIDTH-1:0]       req_data_i,
  output logic [NUM_WORKERS-1:0]                 req_full_o,
  output logic                                   eng_req_write_o,
  output logic [REQ_WIDTH-1:0]                   eng_req_data_o,
  input  logic                                   eng_req_full_i,
  input  logic                                   eng_res_empty_i,
  input  logic [RES_WIDTH-1:0]                   eng_res_data_i,
  output logic                                   eng_res_read_o,
  output logic [NUM_WORKERS-1:0]                 res_write_o,
  output logic [RES_WIDTH-1:0]                   res_data_o,
  input  logic [NUM_WORKERS-1:0]                 res_full_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   idle_o,
  output logic                                   error_o
);

  localparam int IDX_W = $clog2(NUM_WORKERS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_WORKERS-1:0] pending;
  logic [REQ_WIDTH-1:0]   hold [NUM_WORKERS];
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       winner;
  logic                   found;
  int                     idx;
  logic                   grant;
  logic                   error_q;
  logic                   pop;
  logic                   tag_empty;
  logic [IDX_W-1:0]       tag_head;
  logic [CNT_W-1:0]       tag_count;

  // First pending worker at or after rr_ptr, wrapping
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      idx = wrap_add(int'(rr_ptr), i, NUM_WORKERS);
      if (!found && pending[IDX_W'(idx)]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  assign grant = enable_i & found & ~eng_req_full_i & (tag_count < CNT_W'(MAX_OUTSTANDING));

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending         <= '0;
      rr_ptr          <= '0;
      error_q         <= 1'b0;
      eng_req_write_o <= 1'b0;
      eng_req_data_o  <= '0;
    end else begin
      eng_req_write_o <= grant;
      if (grant) begin
        eng_req_data_o <= hold[winner];
        rr_ptr         <= IDX_W'(wrap_add(int'(winner), 1, NUM_WORKERS));
      end
      for (int w = 0; w < NUM_WORKERS; w++) begin
        if (req_write_i[w] && !pending[w])
          pending[w] <= 1'b1;
        else if (grant && (winner == IDX_W'(w)))
          pending[w] <= 1'b0;
      end
      if ((|(req_write_i & pending)) || (!eng_res_empty_i && tag_empty))
        error_q <= 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    for (int w = 0; w < NUM_WORKERS; w++) begin
      if (req_write_i[w] && !pending[w])
        hold[w] <= req_data_i[w*REQ_WIDTH +: REQ_WIDTH];
    end
  end

  // Results come back in issue order, so the tag head names the owner
  pairhmm_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk      (clock_i),
    .rst_n    (reset_n_i),
    .push     (grant),
    .push_dat (winner),
    .pop      (pop),
    .head_dat (tag_head),
    .empty    (tag_empty),
    .count    (tag_count)
  );

  assign pop            = ~eng_res_empty_i & ~tag_empty & ~res_full_i[tag_head];
  assign eng_res_read_o = pop;
  assign res_write_o    = pop ? (NUM_WORKERS'(1) << tag_head) : '0;
  assign res_data_o     = eng_res_data_i;
  assign req_full_o     = pending;
  assign outstanding_o  = tag_count;
  assign idle_o         = ~(|pending) & (tag_count == '0);
  assign error_o        = error_q;

endmodule

// File: doc/pairhmm_compute_arbiter.md
Name: pairhmm_compute_arbiter

Overview:
Shares one PairHMM compute engine between NUM_WORKERS new-worker cores. It round-robin arbitrates per-worker compute requests onto the single engine request FIFO and tags each issued request with its worker index. Engine results, returned strictly in issue order, are routed back to the owning worker's result FIFO. It sits between N cl_pairhmm_new_worker_core instances and one compute engine, generalising the 1:1 worker/engine pairing to N:1.

Parameters:
NUM_WORKERS, 4, number of worker ports (2..16)
REQ_WIDTH, 128, bit width of request_t
RES_WIDTH, 96, bit width of result_t
MAX_OUTSTANDING, 16, tag FIFO depth, power of 2; max requests in flight in the engine

Ports:
clock_i  in  1  clock
reset_n_i  in  1  asynchronous, active-low reset
enable_i  in  1  when 0, no new grants; result draining continues
req_write_i  in  NUM_WORKERS  per-worker request write strobe
req_data_i  in  NUM_WORKERS*REQ_WIDTH  per-worker request; worker w at [w*REQ_WIDTH +: REQ_WIDTH]
req_full_o  out  NUM_WORKERS  per-worker holding register occupied
eng_req_write_o  out  1  request write to engine FIFO
eng_req_data_o  out  REQ_WIDTH  request to engine
eng_req_full_i  in  1  engine request FIFO full
eng_res_empty_i  in  1  engine result FIFO empty (first-word-fall-through)
eng_res_data_i  in  RES_WIDTH  engine result head
eng_res_read_o  out  1  pop engine result
res_write_o  out  NUM_WORKERS  one-hot result write to the owning worker
res_data_o  out  RES_WIDTH  result data, broadcast to all workers
res_full_i  in  NUM_WORKERS  per-worker result FIFO full
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  requests issued but not yet returned
idle_o  out  1  no pending requests and outstanding_o==0
error_o  out  1  sticky protocol error

Behaviour:
- Reset (async, reset_n_i=0): pending flags=0, rr_ptr=0, tag FIFO empty, outstanding=0, error=0.
  - Output reset values: req_full_o=0, eng_req_write_o=0, eng_req_data_o=0, eng_res_read_o=0, res_write_o=0, outstanding_o=0, idle_o=1, error_o=0.
- Request capture: req_write_i[w] with req_full_o[w]=0 loads hold[w] and sets pending[w] at the edge. req_full_o[w]=pending[w] (registered). A write while full is ignored and sets error_o.
- Grant condition (evaluated on registered state): enable_i & |pending & ~eng_req_full_i & (outstanding < MAX_OUTSTANDING).
- Winner selection: first pending index searching from rr_ptr upward, wrapping.
- On grant, at the edge:
  - eng_req_write_o=1 for exactly one cycle (registered, latency 1), eng_req_data_o=hold[winner].
  - pending[winner] cleared; winner pushed to the tag FIFO; rr_ptr=(winner+1) mod NUM_WORKERS.
- Worker throughput: one request per 2 cycles. Aggregate throughput: 1 request/cycle when ≥2 workers are pending.
- A worker write to w in the same cycle as grant of w is impossible: req_full_o[w]=1 in that cycle.
- Result path (combinational, zero latency): pop = ~eng_res_empty_i & tag_nonempty & ~res_full_i[tag_head].
  - eng_res_read_o=pop; res_write_o=pop ? onehot(tag_head) : 0; res_data_o=eng_res_data_i.
  - The tag FIFO pops on the same edge.
- Head-of-line: if the owning worker is full, the result path stalls. Results are never reordered or dropped.
- outstanding: +1 on grant, -1 on pop, unchanged on both; equals tag FIFO count.
- The full check uses the registered count; there is no same-cycle pop bypass.
- error_o (sticky until reset) sets on either:
  - ~eng_res_empty_i while the tag FIFO is empty (unexpected result); that result is not popped.
  - a write while full.
- enable_i=0 mid-operation: held requests stay pending; in-flight results still drain; idle_o rises once all are drained and none are pending.
- Reset mid-operation clears all tags. The engine must be reset concurrently, otherwise stale results raise error_o.

Decomposition:
- cl_pairhmm_package.vh: worker-index width constant and the request_t/result_t widths feeding REQ_WIDTH/RES_WIDTH.
- Sub-module pairhmm_tag_fifo: synchronous FIFO, depth MAX_OUTSTANDING, width $clog2(NUM_WORKERS), with async active-low reset, FWFT head, and count output.

Test Plan:
- Reset: hold reset_n_i=0 with random inputs -> all outputs at reset values, idle_o=1; release -> no spurious eng_req_write_o.
- Round-robin: workers 0-3 each write once in the same cycle, engine never full -> eng_req_write_o on 4 consecutive cycles in order 0,1,2,3; outstanding_o reaches 4.
- Routing: engine echoes 4 results in order with empty=0 -> res_write_o = 0001, 0010, 0100, 1000 on consecutive cycles; outstanding_o back to 0; idle_o=1.
- Head-of-line stall: res_full_i[1]=1 for 10 cycles while tag head=1 -> eng_res_read_o=0 for those cycles; worker 2's result is not delivered before worker 1's.
- Backpressure:
  - MAX_OUTSTANDING=16, results withheld, continuous requests -> exactly 16 grants, then none.
  - eng_req_full_i=1 -> zero grants.
- Protocol errors:
  - eng_res_empty_i=0 with no outstanding -> error_o=1 next cycle, eng_res_read_o=0.
  - write while req_full_o[w]=1 -> error_o=1; the held request is unchanged.
